// File: rtl/tick_debouncer_if.sv
// Button conditioning bus between board pins, tick source and game logic.
// Latency: none (wiring only).
// Backpressure: none; tick is a free-running enable, outputs are strobes.
interface tick_debouncer_if #(
  parameter int N_BTN = 4
);
  logic             tick;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  // Driver side: the pins and the divider.
  modport master (
    output tick,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  // Debouncer side.
  modport slave (
    input  tick,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/tick_debouncer.sv
// Per-button 2-flop sync + tick-qualified debounce with press/release/auto-repeat strobes.
// Latency: 2 clk sync + 1 clk entry + STABLE_TICKS qualifying ticks + 1 clk registered output.
// Backpressure: none; strobes are fire-and-forget, one clk wide, never on adjacent clk per channel.
module tick_debouncer #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 8,
  parameter int REPEAT_DELAY = 200,
  parameter int REPEAT_RATE  = 40,
  parameter int CW           = 16
) (
  input logic              clk,
  input logic              rst,
  tick_debouncer_if.slave  dbif
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Compare targets are "count minus one" because the qualifying tick itself
  // is the one that sees the counter at its last value.
  localparam bit            REP_EN     = (REPEAT_DELAY != 0);
  localparam logic [CW-1:0] ST_LAST    = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] DELAY_LAST = REP_EN ? CW'(REPEAT_DELAY - 1) : '0;
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  // Counters stop at all-ones instead of wrapping (matters when repeat is off).
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync_s;

  // Two-flop synchroniser for the asynchronous pin levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= dbif.btn_raw;
      sync_s    <= sync_meta;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rep_q, rep_d;
    logic          first_q, first_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;
    logic          s;
    logic          deb_done;
    logic          rep_hit;
    logic          fire;

    assign s        = sync_s[g];
    assign deb_done = dbif.tick && (cnt_q == ST_LAST);
    assign rep_hit  = REP_EN && (rep_q == (first_q ? DELAY_LAST : RATE_LAST));
    // A repeat that would land right behind another strobe waits for the next
    // tick with the counter parked at its target.
    assign fire     = (state_q == HELD) && s && dbif.tick && rep_hit &&
                      !(press_q || repeat_q);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        rep_q     <= '0;
        first_q   <= 1'b1;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        rep_q     <= rep_d;
        first_q   <= first_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    // Next state and counter update; a level change always beats a tick.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      first_d = first_q;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_d = DEB_PRESS;
            cnt_d   = '0;
          end
        end
        DEB_PRESS: begin
          if (!s) begin
            state_d = IDLE;
          end else if (dbif.tick) begin
            if (cnt_q == ST_LAST) begin
              state_d = HELD;
              cnt_d   = '0;
              rep_d   = '0;
              first_d = 1'b1;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end
        end
        HELD: begin
          if (!s) begin
            state_d = DEB_RELEASE;
            cnt_d   = '0;
          end else if (dbif.tick) begin
            if (fire) begin
              rep_d   = '0;
              first_d = 1'b0;
            end else if (!rep_hit) begin
              rep_d = sat_inc(rep_q);
            end
          end
        end
        DEB_RELEASE: begin
          // rep_q is left untouched so a short dropout resumes the repeat cadence.
          if (s) begin
            state_d = HELD;
          end else if (dbif.tick) begin
            if (cnt_q == ST_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Output decode, registered by the state flops above.
    always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = fire;
      if ((state_q == DEB_PRESS) && s && deb_done) begin
        level_d = 1'b1;
        press_d = 1'b1;
      end
      if ((state_q == DEB_RELEASE) && !s && deb_done) begin
        level_d   = 1'b0;
        release_d = 1'b1;
      end
    end

    assign dbif.btn_level[g]   = level_q;
    assign dbif.btn_press[g]   = press_q;
    assign dbif.btn_release[g] = release_q;
    assign dbif.btn_repeat[g]  = repeat_q;
  end

endmodule

// File: tb/tb_tick_debouncer.sv
// Self-checking bench: randomized stimulus against a behavioural debounce model.
// Latency: model predicts registered outputs cycle by cycle.
// Backpressure: none.
module tb_tick_debouncer;
  localparam int N  = 4;
  localparam int ST = 8;
  localparam int RD = 200;
  localparam int RR = 40;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  tick_debouncer_if #(.N_BTN(N)) dbif ();

  tick_debouncer #(
    .N_BTN(N), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CW(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dbif(dbif)
  );

  always #5 clk = ~clk;

  // Tick source: 0 = every 4th clk, 1 = random, 2 = every clk.
  int tick_mode = 0;
  int tphase = 0;
  always @(negedge clk) begin
    case (tick_mode)
      0: begin
        dbif.tick = (tphase == 3);
        tphase = (tphase + 1) % 4;
      end
      1: dbif.tick = ($urandom_range(0, 2) == 0);
      default: dbif.tick = 1'b1;
    endcase
  end

  // Reference model. A level change is being qualified whenever the synchronised
  // input disagrees with the accepted level on two consecutive clk samples; ticks
  // in such cycles count, any agreeing sample restarts the count. Repeat ticks
  // are ticks seen with the input high on two consecutive samples while accepted
  // high; they accumulate across short dropouts.
  logic [N-1:0] raw_d1 = '0, raw_d2 = '0, s_prev = '0, m_s;
  logic [N-1:0] m_lvl = '0;
  int           dcnt[N];
  int           rcnt[N];
  bit           first[N];
  logic [N-1:0] exp_level = '0, exp_press = '0, exp_release = '0, exp_repeat = '0;

  always @(posedge clk) begin
    if (rst) begin
      raw_d1 = '0; raw_d2 = '0; s_prev = '0; m_lvl = '0;
      exp_level = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
      for (int c = 0; c < N; c++) begin
        dcnt[c] = 0; rcnt[c] = 0; first[c] = 1'b1;
      end
    end else begin
      m_s = raw_d2;
      exp_press = '0; exp_release = '0; exp_repeat = '0;
      for (int c = 0; c < N; c++) begin
        if (m_lvl[c] && m_s[c] && s_prev[c] && dbif.tick && RD != 0) begin
          rcnt[c]++;
          if (rcnt[c] == (first[c] ? RD : RR)) begin
            exp_repeat[c] = 1'b1;
            rcnt[c] = 0;
            first[c] = 1'b0;
          end
        end
        if (m_s[c] != m_lvl[c] && s_prev[c] != m_lvl[c]) begin
          if (dbif.tick) begin
            dcnt[c]++;
            if (dcnt[c] == ST) begin
              dcnt[c] = 0;
              m_lvl[c] = ~m_lvl[c];
              if (m_lvl[c]) begin
                exp_press[c] = 1'b1; rcnt[c] = 0; first[c] = 1'b1;
              end else begin
                exp_release[c] = 1'b1;
              end
            end
          end
        end else begin
          dcnt[c] = 0;
        end
      end
      exp_level = m_lvl;
      s_prev = m_s;
      raw_d2 = raw_d1;
      raw_d1 = dbif.btn_raw;
    end
  end

  // Per-cycle divergence tally and pulse counters.
  int mism = 0;
  int n_press[N], n_rel[N], n_rep[N];
  initial for (int c = 0; c < N; c++) begin n_press[c] = 0; n_rel[c] = 0; n_rep[c] = 0; end
  always @(negedge clk) begin
    if ({dbif.btn_level, dbif.btn_press, dbif.btn_release, dbif.btn_repeat} !==
        {exp_level, exp_press, exp_release, exp_repeat}) begin
      mism++;
      if (mism <= 5)
        $display("model diff t=%0t lvl=%b/%b prs=%b/%b rel=%b/%b rep=%b/%b", $time,
                 dbif.btn_level, exp_level, dbif.btn_press, exp_press,
                 dbif.btn_release, exp_release, dbif.btn_repeat, exp_repeat);
    end
    for (int c = 0; c < N; c++) begin
      n_press[c] += int'(dbif.btn_press[c]);
      n_rel[c]   += int'(dbif.btn_release[c]);
      n_rep[c]   += int'(dbif.btn_repeat[c]);
    end
  end

  // Bounded wait for n ticks; ends just after a negedge so counters have settled.
  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 4000) begin
      @(posedge clk);
      if (dbif.tick) seen++;
      cyc++;
    end
    @(negedge clk); #1;
    if (seen < n) begin
      checks++;
      $display("FAIL wait_ticks: saw %0d ticks, required %0d", seen, n);
    end
  endtask

  task automatic test_reset();
    int m0;
    rst = 1'b1;
    dbif.btn_raw = '0;
    repeat (4) @(negedge clk);
    checks++; if (dbif.btn_level !== '0) $display("FAIL reset_level: got %b want 0", dbif.btn_level); else passed++;
    checks++; if (dbif.btn_press !== '0) $display("FAIL reset_press: got %b want 0", dbif.btn_press); else passed++;
    checks++; if (dbif.btn_release !== '0) $display("FAIL reset_release: got %b want 0", dbif.btn_release); else passed++;
    checks++; if (dbif.btn_repeat !== '0) $display("FAIL reset_repeat: got %b want 0", dbif.btn_repeat); else passed++;
    m0 = mism;
    rst = 1'b0;
    wait_ticks(100);
    checks++; if ((n_press[0] + n_press[1] + n_press[2] + n_press[3]) !== 0)
      $display("FAIL idle_press: got %0d pulses want 0", n_press[0] + n_press[1] + n_press[2] + n_press[3]); else passed++;
    checks++; if (dbif.btn_level !== '0) $display("FAIL idle_level: got %b want 0", dbif.btn_level); else passed++;
    checks++; if (mism - m0 !== 0) $display("FAIL idle_model: %0d diverging cycles, want 0", mism - m0); else passed++;
  endtask

  task automatic test_press();
    int k = 0, nt = 0, early = 0, m0 = mism;
    bit found = 0;
    @(negedge clk); dbif.btn_raw[0] = 1'b1;
    // edge 1 captures the pin, edge 2 syncs, edge 3 enters DEB_PRESS, edges 4+ count.
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); k++;
      if (k >= 4 && dbif.tick) begin nt++; if (nt == ST) found = 1; end
      @(negedge clk);
      if (!found && dbif.btn_level[0] !== 1'b0) early++;
    end
    checks++; if (early !== 0) $display("FAIL press_early: level high %0d cycles early, want 0", early); else passed++;
    checks++; if (dbif.btn_level[0] !== 1'b1) $display("FAIL press_latency_level: got %b want 1", dbif.btn_level[0]); else passed++;
    checks++; if (dbif.btn_press[0] !== 1'b1) $display("FAIL press_latency_pulse: got %b want 1", dbif.btn_press[0]); else passed++;
    @(negedge clk);
    checks++; if (dbif.btn_press[0] !== 1'b0) $display("FAIL press_width: got %b want 0", dbif.btn_press[0]); else passed++;
    wait_ticks(10);
    checks++; if (n_press[0] !== 1) $display("FAIL press_count: got %0d want 1", n_press[0]); else passed++;
    checks++; if (dbif.btn_level[3:1] !== 3'b000) $display("FAIL press_others: got %b want 000", dbif.btn_level[3:1]); else passed++;
    checks++; if (mism - m0 !== 0) $display("FAIL press_model: %0d diverging cycles, want 0", mism - m0); else passed++;
  endtask

  task automatic test_rst_mid();
    int r0 = n_rel[0], p0;
    @(negedge clk); dbif.btn_raw[0] = 1'b0;
    wait_ticks(4);
    rst = 1'b1; dbif.btn_raw[0] = 1'b1;
    @(negedge clk); #1;
    checks++; if ({dbif.btn_level, dbif.btn_press, dbif.btn_release, dbif.btn_repeat} !== '0)
      $display("FAIL rstmid_outputs: got %h want 0", {dbif.btn_level, dbif.btn_press, dbif.btn_release, dbif.btn_repeat}); else passed++;
    rst = 1'b0;
    p0 = n_press[0];
    wait_ticks(14);
    checks++; if (n_rel[0] !== r0) $display("FAIL rstmid_no_release: got %0d want %0d", n_rel[0], r0); else passed++;
    checks++; if (n_press[0] - p0 !== 1) $display("FAIL rstmid_repress: got %0d want 1", n_press[0] - p0); else passed++;
    checks++; if (dbif.btn_level[0] !== 1'b1) $display("FAIL rstmid_level: got %b want 1", dbif.btn_level[0]); else passed++;
    @(negedge clk); dbif.btn_raw[0] = 1'b0;
    wait_ticks(14);
  endtask

  task automatic test_bounce();
    int p0 = n_press[1], r0 = n_rel[1], m0 = mism;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); dbif.btn_raw[1] = ~t[0];
      repeat ($urandom_range(3, 19)) @(negedge clk);
    end
    @(negedge clk); dbif.btn_raw[1] = 1'b0;
    wait_ticks(3);
    checks++; if (n_press[1] !== p0) $display("FAIL bounce_press: got %0d want %0d", n_press[1], p0); else passed++;
    checks++; if (dbif.btn_level[1] !== 1'b0) $display("FAIL bounce_level: got %b want 0", dbif.btn_level[1]); else passed++;
    @(negedge clk); dbif.btn_raw[1] = 1'b1;
    wait_ticks(14);
    checks++; if (n_press[1] - p0 !== 1) $display("FAIL bounce_hold_press: got %0d want 1", n_press[1] - p0); else passed++;
    @(negedge clk); dbif.btn_raw[1] = 1'b0;
    wait_ticks(14);
    checks++; if (n_rel[1] - r0 !== 1) $display("FAIL bounce_release: got %0d want 1", n_rel[1] - r0); else passed++;
    checks++; if (mism - m0 !== 0) $display("FAIL bounce_model: %0d diverging cycles, want 0", mism - m0); else passed++;
  endtask

  task automatic test_repeat();
    int p0 = n_press[2], q0 = n_rep[2], r0 = n_rel[2], m0 = mism;
    @(negedge clk); dbif.btn_raw[2] = 1'b1;
    wait_ticks(300);
    checks++; if (n_press[2] - p0 !== 1) $display("FAIL repeat_press: got %0d want 1", n_press[2] - p0); else passed++;
    checks++; if (n_rep[2] - q0 !== 3) $display("FAIL repeat_count: got %0d want 3", n_rep[2] - q0); else passed++;
    @(negedge clk); dbif.btn_raw[2] = 1'b0;
    wait_ticks(14);
    checks++; if (n_rel[2] - r0 !== 1) $display("FAIL repeat_release: got %0d want 1", n_rel[2] - r0); else passed++;
    checks++; if (n_rep[2] - q0 !== 3) $display("FAIL repeat_after_release: got %0d want 3", n_rep[2] - q0); else passed++;
    checks++; if (mism - m0 !== 0) $display("FAIL repeat_model: %0d diverging cycles, want 0", mism - m0); else passed++;
  endtask

  task automatic test_dropout();
    int q0 = n_rep[3], r0 = n_rel[3], m0 = mism;
    @(negedge clk); dbif.btn_raw[3] = 1'b1;
    wait_ticks(160);
    @(negedge clk); dbif.btn_raw[3] = 1'b0;
    wait_ticks(5);
    @(negedge clk); dbif.btn_raw[3] = 1'b1;
    wait_ticks(60);
    checks++; if (n_rel[3] !== r0) $display("FAIL dropout_release: got %0d want %0d", n_rel[3], r0); else passed++;
    checks++; if (dbif.btn_level[3] !== 1'b1) $display("FAIL dropout_level: got %b want 1", dbif.btn_level[3]); else passed++;
    checks++; if (n_rep[3] - q0 !== 1) $display("FAIL dropout_resume: got %0d repeats want 1", n_rep[3] - q0); else passed++;
    @(negedge clk); dbif.btn_raw[3] = 1'b0;
    wait_ticks(14);
    checks++; if (mism - m0 !== 0) $display("FAIL dropout_model: %0d diverging cycles, want 0", mism - m0); else passed++;
  endtask

  task automatic test_back_to_back();
    int m0 = mism;
    tick_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 39) == 0) dbif.btn_raw[b] = ~dbif.btn_raw[b];
    end
    checks++; if (mism - m0 !== 0) $display("FAIL random_tick_model: %0d diverging cycles, want 0", mism - m0); else passed++;
    m0 = mism;
    tick_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, (b < 2) ? 14 : 299) == 0) dbif.btn_raw[b] = ~dbif.btn_raw[b];
    end
    dbif.btn_raw = '0;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (mism - m0 !== 0) $display("FAIL continuous_tick_model: %0d diverging cycles, want 0", mism - m0); else passed++;
    checks++; if (dbif.btn_level !== '0) $display("FAIL final_level: got %b want 0", dbif.btn_level); else passed++;
    tick_mode = 0;
  endtask

  initial begin
    dbif.tick = 1'b0;
    dbif.btn_raw = '0;
    rst = 1'b1;
    test_reset();
    test_press();
    test_rst_mid();
    test_bounce();
    test_repeat();
    test_dropout();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
